// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - size encodings, FSM state and lane helpers for mem_access
package mem_access_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   // Size code 3 falls into the default arm and behaves as a word.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_B:    return 4'b0001 << off;
         SZ_H:    return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] sdata);
      case (size)
         SZ_B:    return {4{sdata[7:0]}};
         SZ_H:    return {2{sdata[15:0]}};
         default: return sdata;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// rtl/mem_access_load_align.sv - little-endian lane select and sign/zero extension of load data
module mem_load_align
   import mem_access_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[7:0];
      case (off)
         2'd0: byte_v = rdata[7:0];
         2'd1: byte_v = rdata[15:8];
         2'd2: byte_v = rdata[23:16];
         2'd3: byte_v = rdata[31:24];
         default: byte_v = rdata[7:0];
      endcase
      half_v = off[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_B:    data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
         SZ_H:    data = {{16{~is_unsigned & half_v[15]}}, half_v};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access stage: cache req/ack, load alignment, registered WB bundle
module mem_access
   import mem_access_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_pdata,
   input  logic [DW-1:0] in_sdata,
   input  logic          in_mem_rd,
   input  logic          in_mem_wr,
   input  logic [1:0]    in_size,
   input  logic          in_unsigned,
   input  logic          in_rf_wr,
   input  logic [4:0]    in_rd,
   output logic          dc_req,
   output logic          dc_we,
   output logic [AW-1:0] dc_addr,
   output logic [DW-1:0] dc_wdata,
   output logic [3:0]    dc_be,
   input  logic          dc_ack,
   input  logic [DW-1:0] dc_rdata,
   output logic          out_valid,
   output logic [DW-1:0] out_rdata,
   output logic [AW-1:0] out_pdata,
   output logic          out_needs_wb,
   output logic [4:0]    out_rd,
   output logic          out_misalign
);

   state_e        state_q, state_d;
   logic          dc_req_q, dc_req_d;
   logic          dc_we_q, dc_we_d;
   logic [AW-1:0] dc_addr_q, dc_addr_d;
   logic [DW-1:0] dc_wdata_q, dc_wdata_d;
   logic [3:0]    dc_be_q, dc_be_d;
   logic [1:0]    off_q, off_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic          load_q, load_d;
   logic [4:0]    rd_q, rd_d;
   logic [AW-1:0] pdata_q, pdata_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_rdata_q, out_rdata_d;
   logic [AW-1:0] out_pdata_q, out_pdata_d;
   logic          out_needs_wb_q, out_needs_wb_d;
   logic [4:0]    out_rd_q, out_rd_d;
   logic          out_misalign_q, out_misalign_d;

   logic          accept;
   logic          is_mem;
   logic          bad_align;
   logic [DW-1:0] load_data;

   mem_load_align u_align (
      .rdata       (dc_rdata),
      .off         (off_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .data        (load_data)
   );

   assign accept    = in_valid & (state_q == IDLE);
   assign is_mem    = in_mem_rd | in_mem_wr;
   assign bad_align = misaligned(in_size, in_pdata[1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && is_mem && !bad_align) state_d = WAIT;
         WAIT:    if (dc_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE);
   end

   always_comb begin
      dc_req_d       = dc_req_q;
      dc_we_d        = dc_we_q;
      dc_addr_d      = dc_addr_q;
      dc_wdata_d     = dc_wdata_q;
      dc_be_d        = dc_be_q;
      off_d          = off_q;
      size_d         = size_q;
      uns_d          = uns_q;
      load_d         = load_q;
      rd_d           = rd_q;
      pdata_d        = pdata_q;
      out_valid_d    = 1'b0;
      out_rdata_d    = out_rdata_q;
      out_pdata_d    = out_pdata_q;
      out_needs_wb_d = out_needs_wb_q;
      out_rd_d       = out_rd_q;
      out_misalign_d = out_misalign_q;

      if (accept) begin
         if (!is_mem) begin
            out_valid_d    = 1'b1;
            out_rdata_d    = in_pdata;
            out_pdata_d    = in_pdata;
            out_needs_wb_d = in_rf_wr & (in_rd != 5'd0);
            out_rd_d       = in_rd;
            out_misalign_d = 1'b0;
         end else if (bad_align) begin
            out_valid_d    = 1'b1;
            out_rdata_d    = '0;
            out_pdata_d    = in_pdata;
            out_needs_wb_d = 1'b0;
            out_rd_d       = in_rd;
            out_misalign_d = 1'b1;
         end else begin
            dc_req_d   = 1'b1;
            dc_we_d    = ~in_mem_rd;
            dc_addr_d  = {in_pdata[AW-1:2], 2'b00};
            dc_be_d    = in_mem_rd ? 4'b1111 : byte_en(in_size, in_pdata[1:0]);
            dc_wdata_d = in_mem_rd ? '0 : store_data(in_size, in_sdata);
            off_d      = in_pdata[1:0];
            size_d     = in_size;
            uns_d      = in_unsigned;
            load_d     = in_mem_rd;
            rd_d       = in_rd;
            pdata_d    = in_pdata;
         end
      end else if (state_q == WAIT && dc_ack) begin
         // Request fields stay put until here so the cache sees a stable bundle.
         dc_req_d       = 1'b0;
         out_valid_d    = 1'b1;
         out_rdata_d    = load_q ? load_data : '0;
         out_pdata_d    = pdata_q;
         out_needs_wb_d = load_q & (rd_q != 5'd0);
         out_rd_d       = rd_q;
         out_misalign_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dc_req_q       <= 1'b0;
         dc_we_q        <= 1'b0;
         dc_addr_q      <= '0;
         dc_wdata_q     <= '0;
         dc_be_q        <= '0;
         off_q          <= '0;
         size_q         <= '0;
         uns_q          <= 1'b0;
         load_q         <= 1'b0;
         rd_q           <= '0;
         pdata_q        <= '0;
         out_valid_q    <= 1'b0;
         out_rdata_q    <= '0;
         out_pdata_q    <= '0;
         out_needs_wb_q <= 1'b0;
         out_rd_q       <= '0;
         out_misalign_q <= 1'b0;
      end else begin
         dc_req_q       <= dc_req_d;
         dc_we_q        <= dc_we_d;
         dc_addr_q      <= dc_addr_d;
         dc_wdata_q     <= dc_wdata_d;
         dc_be_q        <= dc_be_d;
         off_q          <= off_d;
         size_q         <= size_d;
         uns_q          <= uns_d;
         load_q         <= load_d;
         rd_q           <= rd_d;
         pdata_q        <= pdata_d;
         out_valid_q    <= out_valid_d;
         out_rdata_q    <= out_rdata_d;
         out_pdata_q    <= out_pdata_d;
         out_needs_wb_q <= out_needs_wb_d;
         out_rd_q       <= out_rd_d;
         out_misalign_q <= out_misalign_d;
      end
   end

   assign dc_req       = dc_req_q;
   assign dc_we        = dc_we_q;
   assign dc_addr      = dc_addr_q;
   assign dc_wdata     = dc_wdata_q;
   assign dc_be        = dc_be_q;
   assign out_valid    = out_valid_q;
   assign out_rdata    = out_rdata_q;
   assign out_pdata    = out_pdata_q;
   assign out_needs_wb = out_needs_wb_q;
   assign out_rd       = out_rd_q;
   assign out_misalign = out_misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed vector bench for mem_access
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pdata;
   logic [31:0] in_sdata;
   logic        in_mem_rd;
   logic        in_mem_wr;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic        in_rf_wr;
   logic [4:0]  in_rd;
   logic        dc_req;
   logic        dc_we;
   logic [31:0] dc_addr;
   logic [31:0] dc_wdata;
   logic [3:0]  dc_be;
   logic        dc_ack;
   logic [31:0] dc_rdata;
   logic        out_valid;
   logic [31:0] out_rdata;
   logic [31:0] out_pdata;
   logic        out_needs_wb;
   logic [4:0]  out_rd;
   logic        out_misalign;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pdata(in_pdata), .in_sdata(in_sdata),
      .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
      .in_size(in_size), .in_unsigned(in_unsigned),
      .in_rf_wr(in_rf_wr), .in_rd(in_rd),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
      .dc_wdata(dc_wdata), .dc_be(dc_be),
      .dc_ack(dc_ack), .dc_rdata(dc_rdata),
      .out_valid(out_valid), .out_rdata(out_rdata), .out_pdata(out_pdata),
      .out_needs_wb(out_needs_wb), .out_rd(out_rd), .out_misalign(out_misalign)
   );

   typedef struct {
      logic [31:0] pdata;
      logic [31:0] sdata;
      logic        mem_rd;
      logic        mem_wr;
      logic [1:0]  size;
      logic        uns;
      logic        rf_wr;
      logic [4:0]  rd;
      int          delay;
      logic [31:0] rdata;
      logic        exp_req;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic        chk_rdata;
      logic        exp_wb;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = 0; in_pdata = 0; in_sdata = 0; in_mem_rd = 0; in_mem_wr = 0;
      in_size = 0; in_unsigned = 0; in_rf_wr = 0; in_rd = 0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      chk($sformatf("v%0d idle_ready", idx), 32'(in_ready), 32'd1);
      in_valid = 1; in_pdata = v.pdata; in_sdata = v.sdata; in_mem_rd = v.mem_rd;
      in_mem_wr = v.mem_wr; in_size = v.size; in_unsigned = v.uns;
      in_rf_wr = v.rf_wr; in_rd = v.rd;
      step();
      clear_inputs();
      chk($sformatf("v%0d dc_req", idx), 32'(dc_req), 32'(v.exp_req));
      if (v.exp_req) begin
         chk($sformatf("v%0d dc_addr", idx), dc_addr, v.exp_addr);
         chk($sformatf("v%0d dc_be", idx), 32'(dc_be), 32'(v.exp_be));
         chk($sformatf("v%0d dc_we", idx), 32'(dc_we), 32'(v.exp_we));
         chk($sformatf("v%0d dc_wdata", idx), dc_wdata, v.exp_wdata);
         for (int i = 0; i < v.delay; i++) begin
            chk($sformatf("v%0d wait_ready", idx), 32'(in_ready), 32'd0);
            chk($sformatf("v%0d wait_req", idx), 32'(dc_req), 32'd1);
            chk($sformatf("v%0d wait_addr", idx), dc_addr, v.exp_addr);
            chk($sformatf("v%0d wait_valid", idx), 32'(out_valid), 32'd0);
            step();
         end
         dc_ack = 1; dc_rdata = v.rdata;
         step();
         dc_ack = 0; dc_rdata = 32'h5A5A_5A5A;
         chk($sformatf("v%0d req_drop", idx), 32'(dc_req), 32'd0);
      end
      chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d ret_ready", idx), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d needs_wb", idx), 32'(out_needs_wb), 32'(v.exp_wb));
      chk($sformatf("v%0d misalign", idx), 32'(out_misalign), 32'(v.exp_mis));
      chk($sformatf("v%0d out_pdata", idx), out_pdata, v.pdata);
      chk($sformatf("v%0d out_rd", idx), 32'(out_rd), 32'(v.rd));
      if (v.chk_rdata) chk($sformatf("v%0d out_rdata", idx), out_rdata, v.exp_rdata);
      step();
      chk($sformatf("v%0d valid_pulse", idx), 32'(out_valid), 32'd0);
   endtask

   initial begin
      //             pdata         sdata         rd wr size  u  rfw rd    dly rdata         req we addr          be       wdata         rdata         chk wb mis
      vecs[0]  = '{32'h0000_1003, 32'h0,        1, 0, SZ_B, 0, 0, 5'd7, 3, 32'h80FF_FF7F, 1, 0, 32'h0000_1000, 4'b1111, 32'h0,        32'hFFFF_FF80, 1, 1, 0};
      vecs[1]  = '{32'h0000_2002, 32'h1234_ABCD, 0, 1, SZ_H, 0, 0, 5'd9, 1, 32'h0,        1, 1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0,        0, 0, 0};
      vecs[2]  = '{32'h0000_3001, 32'h0,        1, 0, SZ_W, 0, 0, 5'd4, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0, 1};
      vecs[3]  = '{32'h0000_3002, 32'h0,        1, 0, SZ_H, 1, 0, 5'd3, 0, 32'hBEEF_0000, 1, 0, 32'h0000_3000, 4'b1111, 32'h0,        32'h0000_BEEF, 1, 1, 0};
      vecs[4]  = '{32'h0000_4000, 32'h0,        1, 0, SZ_B, 0, 0, 5'd0, 1, 32'h1234_5678, 1, 0, 32'h0000_4000, 4'b1111, 32'h0,        32'h0000_0078, 1, 0, 0};
      vecs[5]  = '{32'h0000_5001, 32'h0000_00AB, 0, 1, SZ_B, 0, 0, 5'd2, 2, 32'h0,        1, 1, 32'h0000_5000, 4'b0010, 32'hABAB_ABAB, 32'h0,        0, 0, 0};
      vecs[6]  = '{32'h0000_6000, 32'h0,        1, 0, SZ_H, 0, 0, 5'd8, 0, 32'h0000_8001, 1, 0, 32'h0000_6000, 4'b1111, 32'h0,        32'hFFFF_8001, 1, 1, 0};
      vecs[7]  = '{32'hCAFE_0001, 32'h0,        0, 0, SZ_W, 0, 1, 5'd0, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'hCAFE_0001, 1, 0, 0};
      vecs[8]  = '{32'h0000_7000, 32'h0,        1, 0, 2'd3, 0, 0, 5'd6, 1, 32'hDEAD_BEEF, 1, 0, 32'h0000_7000, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1, 1, 0};
      vecs[9]  = '{32'h0000_8000, 32'hCAFE_F00D, 1, 1, SZ_B, 1, 0, 5'd1, 0, 32'h0000_00F0, 1, 0, 32'h0000_8000, 4'b1111, 32'h0,        32'h0000_00F0, 1, 1, 0};
      vecs[10] = '{32'h0000_9001, 32'h0000_1111, 0, 1, SZ_H, 0, 0, 5'd5, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0, 1};

      clear_inputs();
      dc_ack = 0; dc_rdata = 0;
      rst_n = 0;
      repeat (3) step();
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst dc_req", 32'(dc_req), 32'd0);
      chk("rst dc_be", 32'(dc_be), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_rdata", out_rdata, 32'd0);
      chk("rst out_misalign", 32'(out_misalign), 32'd0);
      rst_n = 1;
      step();

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Back-to-back ALU passthrough: one retire per cycle.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_rf_wr = 1; in_rd = 5'd5; in_pdata = 32'h11 * (i + 1);
         step();
         chk($sformatf("b2b%0d out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("b2b%0d out_rdata", i), out_rdata, 32'h11 * (i + 1));
         chk($sformatf("b2b%0d needs_wb", i), 32'(out_needs_wb), 32'd1);
         chk($sformatf("b2b%0d in_ready", i), 32'(in_ready), 32'd1);
      end
      clear_inputs();
      step();
      chk("b2b tail valid", 32'(out_valid), 32'd0);

      // Stray ack while idle must not retire anything.
      dc_ack = 1;
      step();
      dc_ack = 0;
      chk("idle ack valid", 32'(out_valid), 32'd0);

      // Asynchronous reset in WAIT withdraws the request; a late ack is ignored.
      in_valid = 1; in_mem_rd = 1; in_size = SZ_W; in_pdata = 32'h0000_A000; in_rd = 5'd3;
      step();
      clear_inputs();
      chk("rstwait req_up", 32'(dc_req), 32'd1);
      chk("rstwait ready_low", 32'(in_ready), 32'd0);
      #2 rst_n = 0;
      #1;
      chk("rstwait req_async", 32'(dc_req), 32'd0);
      chk("rstwait ready_async", 32'(in_ready), 32'd1);
      step();
      rst_n = 1;
      dc_ack = 1; dc_rdata = 32'h1234_5678;
      step();
      dc_ack = 0;
      chk("rstwait late_ack valid", 32'(out_valid), 32'd0);
      step();
      chk("rstwait late_ack valid2", 32'(out_valid), 32'd0);
      chk("rstwait req_stays", 32'(dc_req), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
